// File: rtl/sound_ram_reader.sv
// Playback reader for the 512x32 sound RAM: fetches a frame's words after each
// msec edge and plays them out one byte (LSB first) per sample_tick.
module sound_ram_reader #(
  parameter int unsigned RD_LAT   = 2,
  parameter logic [7:0]  IDLE_VAL = 8'h80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msec,
  input  logic [8:0]  frame_words,
  input  logic        sample_tick,
  input  logic [31:0] q_sound,
  output logic [8:0]  rd_sound,
  output logic [7:0]  sample,
  output logic        sample_stb,
  output logic        underrun,
  output logic        busy
);

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_msec_d;
  logic [AW-1:0] r_words_left;
  logic [LW-1:0] r_lat;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_pre;
  logic          r_hold_v;
  logic          r_pre_v;
  logic [1:0]    r_byte_idx;

  logic          w_fr;
  logic          w_cap;
  logic          w_play;
  logic          w_consume;
  logic          w_last_word;
  logic          w_done;
  logic [DW-1:0] w_hold_nxt;
  logic [DW-1:0] w_pre_nxt;
  logic          w_hold_v_nxt;
  logic          w_pre_v_nxt;

  assign w_fr        = msec & ~r_msec_d;
  assign w_cap       = (r_state == S_FETCH) && (r_lat == LW'(RD_LAT));
  assign w_play      = sample_tick & r_hold_v;
  assign w_consume   = w_play && (r_byte_idx == 2'd3);
  assign w_last_word = (r_words_left == AW'(1));
  assign w_done      = (r_state == S_DRAIN) && w_consume && !r_pre_v;

  // Slot shuffle: consumption promotes pre first, so a captured word lands in
  // whichever slot is free afterwards and nothing is lost or duplicated.
  always_comb begin
    w_hold_nxt   = r_hold;
    w_hold_v_nxt = r_hold_v;
    w_pre_nxt    = r_pre;
    w_pre_v_nxt  = r_pre_v;
    if (w_consume) begin
      w_hold_nxt   = r_pre;
      w_hold_v_nxt = r_pre_v;
      w_pre_v_nxt  = 1'b0;
    end
    if (w_cap) begin
      if (!w_hold_v_nxt) begin
        w_hold_nxt   = q_sound;
        w_hold_v_nxt = 1'b1;
      end else begin
        w_pre_nxt    = q_sound;
        w_pre_v_nxt  = 1'b1;
      end
    end
  end

  // Next-state logic; a frame edge overrides whatever the FSM was doing.
  always_comb begin
    w_state_nxt = r_state;
    if (w_fr) begin
      w_state_nxt = (frame_words != '0) ? S_FETCH : S_IDLE;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_cap) begin
            if (w_last_word)                     w_state_nxt = S_DRAIN;
            else if (w_hold_v_nxt && w_pre_v_nxt) w_state_nxt = S_WAIT;
          end
        end
        S_WAIT:  if (w_consume) w_state_nxt = S_FETCH;
        S_DRAIN: if (w_done)    w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msec_d     <= 1'b0;
      rd_sound     <= '0;
      sample       <= IDLE_VAL;
      sample_stb   <= 1'b0;
      underrun     <= 1'b0;
      busy         <= 1'b0;
      r_words_left <= '0;
      r_lat        <= '0;
      r_hold       <= '0;
      r_pre        <= '0;
      r_hold_v     <= 1'b0;
      r_pre_v      <= 1'b0;
      r_byte_idx   <= '0;
    end else begin
      r_msec_d   <= msec;
      // Tick output uses the state as it was before any same-cycle frame edge.
      sample_stb <= sample_tick;
      underrun   <= sample_tick & busy & ~r_hold_v;
      if (w_play)           sample <= r_hold[{r_byte_idx, 3'b000} +: 8];
      else if (sample_tick) sample <= IDLE_VAL;

      if (w_fr) begin
        r_words_left <= frame_words;
        rd_sound     <= '0;
        r_byte_idx   <= '0;
        r_lat        <= '0;
        r_hold_v     <= 1'b0;
        r_pre_v      <= 1'b0;
        busy         <= (frame_words != '0);
      end else begin
        r_hold   <= w_hold_nxt;
        r_hold_v <= w_hold_v_nxt;
        r_pre    <= w_pre_nxt;
        r_pre_v  <= w_pre_v_nxt;
        r_lat    <= (r_state == S_FETCH && !w_cap) ? r_lat + LW'(1) : '0;
        if (w_play) r_byte_idx <= r_byte_idx + 2'd1;
        if (w_cap) begin
          r_words_left <= r_words_left - AW'(1);
          if (!w_last_word) rd_sound <= rd_sound + AW'(1);
        end
        if (w_done) busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sound_ram_reader.sv
// Bench for sound_ram_reader: two instances (RD_LAT 2 and 3) share stimulus;
// each has its own pipelined RAM model and output recorder.
module tb_sound_ram_reader;

  localparam int unsigned NI    = 2;
  localparam int unsigned DEPTH = 1024;
  localparam logic [7:0]  IDLE  = 8'h80;

  logic        clk = 1'b0;
  logic        reset;
  logic        msec;
  logic        sample_tick;
  logic [8:0]  frame_words;

  logic [31:0] mem [512];
  logic [31:0] q_a    [NI];
  logic [8:0]  rd_a   [NI];
  logic [7:0]  smp_a  [NI];
  logic        stb_a  [NI];
  logic        un_a   [NI];
  logic        busy_a [NI];
  logic [31:0] p2 [2];
  logic [31:0] p3 [3];

  logic [7:0]  smp_m [NI][DEPTH];
  logic        un_m  [NI][DEPTH];
  logic        bsy_m [NI][DEPTH];
  logic [8:0]  rd_m  [NI][DEPTH];
  logic [8:0]  rd_last [NI];
  int          n_smp [NI];
  int          n_rd  [NI];
  int          n_un  [NI];
  int          n_busy[NI];

  int errors;
  int checks;

  always #5 clk = ~clk;

  sound_ram_reader #(.RD_LAT(2), .IDLE_VAL(8'h80)) u_dut2 (
    .clk(clk), .reset(reset), .msec(msec), .frame_words(frame_words),
    .sample_tick(sample_tick), .q_sound(q_a[0]), .rd_sound(rd_a[0]),
    .sample(smp_a[0]), .sample_stb(stb_a[0]), .underrun(un_a[0]), .busy(busy_a[0])
  );

  sound_ram_reader #(.RD_LAT(3), .IDLE_VAL(8'h80)) u_dut3 (
    .clk(clk), .reset(reset), .msec(msec), .frame_words(frame_words),
    .sample_tick(sample_tick), .q_sound(q_a[1]), .rd_sound(rd_a[1]),
    .sample(smp_a[1]), .sample_stb(stb_a[1]), .underrun(un_a[1]), .busy(busy_a[1])
  );

  // RAM read port: data for an address appears RD_LAT cycles after it is presented.
  always @(posedge clk) begin
    p2[0] <= mem[rd_a[0]];
    p2[1] <= p2[0];
    p3[0] <= mem[rd_a[1]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign q_a[0] = p2[1];
  assign q_a[1] = p3[2];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (stb_a[i] === 1'b1 && n_smp[i] < DEPTH) begin
        smp_m[i][n_smp[i]] <= smp_a[i];
        un_m[i][n_smp[i]]  <= un_a[i];
        bsy_m[i][n_smp[i]] <= busy_a[i];
        n_smp[i]           <= n_smp[i] + 1;
      end
      if (un_a[i] === 1'b1)   n_un[i]   <= n_un[i] + 1;
      if (busy_a[i] === 1'b1) n_busy[i] <= n_busy[i] + 1;
      if (rd_a[i] !== rd_last[i] && n_rd[i] < DEPTH) begin
        rd_m[i][n_rd[i]] <= rd_a[i];
        n_rd[i]          <= n_rd[i] + 1;
        rd_last[i]       <= rd_a[i];
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int unsigned b);
    byte_of = 8'(w >> (8 * b));
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_tick();
    step(1);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic start_frame(input int fw);
    step(1);
    msec        = 1'b1;
    frame_words = 9'(fw);
    step(1);
    frame_words = 9'($urandom);
    step(2);
    msec        = 1'b0;
  endtask

  task automatic test_reset();
    int b [NI];
    step(1);
    for (int i = 0; i < NI; i++) begin
      checks++; if (rd_a[i] !== 9'd0) begin errors++; $display("FAIL reset_rd[%0d]: got %0d want 0", i, rd_a[i]); end
      checks++; if (smp_a[i] !== IDLE) begin errors++; $display("FAIL reset_sample[%0d]: got %h want 80", i, smp_a[i]); end
      checks++; if (stb_a[i] !== 1'b0) begin errors++; $display("FAIL reset_stb[%0d]: got %b want 0", i, stb_a[i]); end
      checks++; if (un_a[i] !== 1'b0) begin errors++; $display("FAIL reset_underrun[%0d]: got %b want 0", i, un_a[i]); end
      checks++; if (busy_a[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_a[i]); end
    end
    for (int w = 0; w < 4; w++) mem[w] = $urandom;
    start_frame(4);
    step(6);
    repeat (3) begin do_tick(); step(4); end
    for (int i = 0; i < NI; i++) begin
      checks++; if (busy_a[i] !== 1'b1) begin errors++; $display("FAIL midframe_busy[%0d]: got %b want 1", i, busy_a[i]); end
    end
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++; if (rd_a[i] !== 9'd0) begin errors++; $display("FAIL areset_rd[%0d]: got %0d want 0", i, rd_a[i]); end
      checks++; if (smp_a[i] !== IDLE) begin errors++; $display("FAIL areset_sample[%0d]: got %h want 80", i, smp_a[i]); end
      checks++; if (stb_a[i] !== 1'b0) begin errors++; $display("FAIL areset_stb[%0d]: got %b want 0", i, stb_a[i]); end
      checks++; if (un_a[i] !== 1'b0) begin errors++; $display("FAIL areset_underrun[%0d]: got %b want 0", i, un_a[i]); end
      checks++; if (busy_a[i] !== 1'b0) begin errors++; $display("FAIL areset_busy[%0d]: got %b want 0", i, busy_a[i]); end
      b[i] = n_smp[i];
    end
    step(2);
    reset = 1'b0;
    step(10);
    for (int i = 0; i < NI; i++) begin
      checks++; if (n_smp[i] != b[i]) begin errors++; $display("FAIL post_reset_quiet[%0d]: got %0d strobes want 0", i, n_smp[i] - b[i]); end
    end
    do_tick();
    step(3);
    for (int i = 0; i < NI; i++) begin
      checks++; if (n_smp[i] != b[i] + 1) begin errors++; $display("FAIL post_reset_tick_count[%0d]: got %0d want 1", i, n_smp[i] - b[i]); end
      else begin
        checks++; if (smp_m[i][b[i]] !== IDLE || un_m[i][b[i]] !== 1'b0) begin
          errors++; $display("FAIL post_reset_tick[%0d]: got %h/u%b want 80/u0", i, smp_m[i][b[i]], un_m[i][b[i]]);
        end
      end
    end
  endtask

  task automatic test_silent();
    int bs [NI]; int br [NI]; int bu [NI]; int bb [NI];
    for (int w = 0; w < 8; w++) mem[w] = $urandom;
    for (int i = 0; i < NI; i++) begin bs[i] = n_smp[i]; br[i] = n_rd[i]; bu[i] = n_un[i]; bb[i] = n_busy[i]; end
    start_frame(0);
    step(3);
    repeat (6) begin do_tick(); step(3); end
    step(3);
    for (int i = 0; i < NI; i++) begin
      checks++; if (n_smp[i] - bs[i] != 6) begin errors++; $display("FAIL silent_count[%0d]: got %0d want 6", i, n_smp[i] - bs[i]); end
      for (int k = 0; k < 6 && bs[i] + k < n_smp[i]; k++) begin
        checks++; if (smp_m[i][bs[i]+k] !== IDLE || un_m[i][bs[i]+k] !== 1'b0) begin
          errors++; $display("FAIL silent_sample[%0d][%0d]: got %h/u%b want 80/u0", i, k, smp_m[i][bs[i]+k], un_m[i][bs[i]+k]);
        end
      end
      checks++; if (n_rd[i] != br[i]) begin errors++; $display("FAIL silent_rd[%0d]: got %0d changes want 0", i, n_rd[i] - br[i]); end
      checks++; if (n_busy[i] != bb[i]) begin errors++; $display("FAIL silent_busy[%0d]: got %0d busy cycles want 0", i, n_busy[i] - bb[i]); end
      checks++; if (n_un[i] != bu[i]) begin errors++; $display("FAIL silent_underrun[%0d]: got %0d want 0", i, n_un[i] - bu[i]); end
    end
  endtask

  task automatic test_two_words();
    int bs [NI]; int br [NI];
    logic [7:0] exp_s [10];
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    mem[2] = $urandom;
    for (int k = 0; k < 10; k++) exp_s[k] = (k < 8) ? byte_of(mem[k/4], k % 4) : IDLE;
    for (int i = 0; i < NI; i++) begin bs[i] = n_smp[i]; br[i] = n_rd[i]; end
    start_frame(2);
    step(6);
    repeat (10) begin do_tick(); step(18); end
    for (int i = 0; i < NI; i++) begin
      checks++; if (n_smp[i] - bs[i] != 10) begin errors++; $display("FAIL two_count[%0d]: got %0d want 10", i, n_smp[i] - bs[i]); end
      for (int k = 0; k < 10 && bs[i] + k < n_smp[i]; k++) begin
        checks++; if (smp_m[i][bs[i]+k] !== exp_s[k] || un_m[i][bs[i]+k] !== 1'b0) begin
          errors++; $display("FAIL two_sample[%0d][%0d]: got %h/u%b want %h/u0", i, k, smp_m[i][bs[i]+k], un_m[i][bs[i]+k], exp_s[k]);
        end
        if (k != 7) begin
          checks++; if (bsy_m[i][bs[i]+k] !== (k < 7)) begin
            errors++; $display("FAIL two_busy[%0d][%0d]: got %b want %b", i, k, bsy_m[i][bs[i]+k], k < 7);
          end
        end
      end
      checks++; if (n_rd[i] - br[i] != 1) begin errors++; $display("FAIL two_rd_changes[%0d]: got %0d want 1", i, n_rd[i] - br[i]); end
      else begin
        checks++; if (rd_m[i][br[i]] !== 9'd1) begin errors++; $display("FAIL two_rd_seq[%0d]: got %0d want 1", i, rd_m[i][br[i]]); end
      end
      checks++; if (busy_a[i] !== 1'b0) begin errors++; $display("FAIL two_busy_end[%0d]: got %b want 0", i, busy_a[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int bs [NI]; int cnt; int nu;
    logic [31:0] w [3];
    logic [7:0] f [$];
    logic [7:0] e;
    for (int k = 0; k < 3; k++) begin w[k] = $urandom; mem[k] = w[k]; end
    for (int i = 0; i < NI; i++) bs[i] = n_smp[i];
    step(1);
    msec        = 1'b1;
    frame_words = 9'd3;
    step(1);
    sample_tick = 1'b1;
    frame_words = 9'($urandom);
    step(24);
    sample_tick = 1'b0;
    msec        = 1'b0;
    step(4);
    for (int i = 0; i < NI; i++) begin
      cnt = n_smp[i] - bs[i];
      checks++; if (cnt != 24) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want 24", i, cnt); end
      checks++; if (cnt < 1 || un_m[i][bs[i]] !== 1'b1) begin errors++; $display("FAIL b2b_lead_underrun[%0d]: got none want underrun on first tick", i); end
      f.delete();
      nu = 0;
      for (int k = 0; k < cnt; k++) begin
        if (un_m[i][bs[i]+k] === 1'b1) begin
          nu++;
          checks++; if (smp_m[i][bs[i]+k] !== IDLE) begin errors++; $display("FAIL b2b_underrun_val[%0d][%0d]: got %h want 80", i, k, smp_m[i][bs[i]+k]); end
        end else f.push_back(smp_m[i][bs[i]+k]);
      end
      checks++; if (f.size() < 12) begin errors++; $display("FAIL b2b_data_count[%0d]: got %0d want >=12 (underruns %0d)", i, f.size(), nu); end
      for (int k = 0; k < f.size(); k++) begin
        e = (k < 12) ? byte_of(w[k/4], k % 4) : IDLE;
        checks++; if (f[k] !== e) begin errors++; $display("FAIL b2b_data[%0d][%0d]: got %h want %h", i, k, f[k], e); end
      end
    end
  endtask

  task automatic test_abort();
    int bs [NI]; int cnt;
    logic [31:0] w [3];
    logic [31:0] nw;
    logic [7:0] f [$];
    logic [7:0] e;
    for (int k = 0; k < 3; k++) begin w[k] = $urandom; mem[k] = w[k]; end
    nw = $urandom;
    for (int i = 0; i < NI; i++) bs[i] = n_smp[i];
    start_frame(3);
    step(8);
    for (int k = 0; k < 14; k++) begin
      do_tick();
      step(4);
      if (k == 4) begin
        mem[0] = nw;
        start_frame(1);
      end
    end
    step(4);
    for (int i = 0; i < NI; i++) begin
      cnt = n_smp[i] - bs[i];
      checks++; if (cnt != 14) begin errors++; $display("FAIL abort_count[%0d]: got %0d want 14", i, cnt); end
      for (int k = 0; k < 5 && k < cnt; k++) begin
        e = byte_of(w[k/4], k % 4);
        checks++; if (smp_m[i][bs[i]+k] !== e || un_m[i][bs[i]+k] !== 1'b0) begin
          errors++; $display("FAIL abort_old[%0d][%0d]: got %h/u%b want %h/u0", i, k, smp_m[i][bs[i]+k], un_m[i][bs[i]+k], e);
        end
      end
      f.delete();
      for (int k = 5; k < cnt; k++) begin
        if (un_m[i][bs[i]+k] === 1'b1) begin
          checks++; if (smp_m[i][bs[i]+k] !== IDLE) begin errors++; $display("FAIL abort_underrun_val[%0d][%0d]: got %h want 80", i, k, smp_m[i][bs[i]+k]); end
        end else f.push_back(smp_m[i][bs[i]+k]);
      end
      checks++; if (f.size() < 4) begin errors++; $display("FAIL abort_data_count[%0d]: got %0d want >=4", i, f.size()); end
      for (int k = 0; k < f.size(); k++) begin
        e = (k < 4) ? byte_of(nw, k) : IDLE;
        checks++; if (f[k] !== e) begin errors++; $display("FAIL abort_new[%0d][%0d]: got %h want %h", i, k, f[k], e); end
      end
      checks++; if (rd_a[i] !== 9'd0) begin errors++; $display("FAIL abort_rd[%0d]: got %0d want 0", i, rd_a[i]); end
      checks++; if (busy_a[i] !== 1'b0) begin errors++; $display("FAIL abort_busy[%0d]: got %b want 0", i, busy_a[i]); end
    end
  endtask

  task automatic test_long();
    int bs [NI]; int br [NI]; int bu [NI]; int cnt;
    logic [7:0] e;
    for (int k = 0; k < 100; k++) mem[k] = $urandom;
    for (int i = 0; i < NI; i++) begin bs[i] = n_smp[i]; br[i] = n_rd[i]; bu[i] = n_un[i]; end
    start_frame(100);
    step(8);
    repeat (404) begin do_tick(); step(2); end
    step(4);
    for (int i = 0; i < NI; i++) begin
      cnt = n_smp[i] - bs[i];
      checks++; if (cnt != 404) begin errors++; $display("FAIL long_count[%0d]: got %0d want 404", i, cnt); end
      for (int k = 0; k < cnt; k++) begin
        e = (k < 400) ? byte_of(mem[k/4], k % 4) : IDLE;
        checks++; if (smp_m[i][bs[i]+k] !== e) begin errors++; $display("FAIL long_sample[%0d][%0d]: got %h want %h", i, k, smp_m[i][bs[i]+k], e); end
      end
      checks++; if (n_un[i] != bu[i]) begin errors++; $display("FAIL long_underrun[%0d]: got %0d want 0", i, n_un[i] - bu[i]); end
      checks++; if (rd_a[i] !== 9'd99) begin errors++; $display("FAIL long_rd_end[%0d]: got %0d want 99", i, rd_a[i]); end
      checks++; if (n_rd[i] - br[i] != 99) begin errors++; $display("FAIL long_rd_changes[%0d]: got %0d want 99", i, n_rd[i] - br[i]); end
      for (int k = 0; k < 99 && br[i] + k < n_rd[i]; k++) begin
        checks++; if (rd_m[i][br[i]+k] !== 9'(k + 1)) begin errors++; $display("FAIL long_rd_seq[%0d][%0d]: got %0d want %0d", i, k, rd_m[i][br[i]+k], k + 1); end
      end
      checks++; if (busy_a[i] !== 1'b0) begin errors++; $display("FAIL long_busy_end[%0d]: got %b want 0", i, busy_a[i]); end
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    msec        = 1'b0;
    sample_tick = 1'b0;
    frame_words = '0;
    for (int k = 0; k < 512; k++) mem[k] = $urandom;
    step(3);
    reset = 1'b0;
    test_reset();
    test_silent();
    test_two_words();
    test_back_to_back();
    test_abort();
    test_long();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
